pipe_shifter: RTL and testbench

- Parametrised, pipelined successor to the fixed 16-bit shift-by-8 zero-fill stage.
- Shifts or rotates a WIDTH-bit operand by any amount 0..WIDTH-1 in four modes: ROL, SLL, ROR and SRL.
- Uses one registered stage per shift-amount bit.
- Sits between the decode/operand-fetch stage and the execute result mux. A valid/ready handshake lets the datapath stall it.

---
 rtl/pipe_shifter_pkg.sv | 23 ++
 rtl/pipe_shifter_stage.sv | 74 +++++++
 rtl/pipe_shifter.sv | 66 ++++++
 tb/tb_pipe_shifter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_shifter_pkg.sv
// Shared definitions for the pipelined shifter: operation encodings (also used by
// the ALU opcode decoder) and the width helper that sizes the pipeline.
`timescale 1ns/1ps
package pipe_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_ROL = 2'b00,
        MODE_SLL = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } mode_e;

    // Ceiling log2 for elaboration-time sizing; valid for values up to 2^31.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_shifter_stage.sv
// One pipeline stage: conditionally shifts/rotates by the fixed amount AMT,
// then registers the result with valid/hold/flush handling.
`timescale 1ns/1ps
module shift_stage
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int AMT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_mode,
    input  logic             next_advance,
    output logic             advance,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic [1:0]       out_mode
);

    mode_e            mode_sel;
    logic [WIDTH-1:0] shifted;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mode_q;

    assign mode_sel = mode_e'(in_mode);

    // The LSB of the remaining count belongs to this stage.
    always_comb begin
        // NOTE: default assignment first so no path leaves shifted unassigned (no latch).
        shifted = in_data;
        if (in_cnt[0]) begin
            unique case (mode_sel)
                MODE_ROL: shifted = (in_data << AMT) | (in_data >> (WIDTH - AMT));
                MODE_SLL: shifted = in_data << AMT;
                MODE_ROR: shifted = (in_data >> AMT) | (in_data << (WIDTH - AMT));
                MODE_SRL: shifted = in_data >> AMT;
            endcase
        end
    end

    // An empty stage always accepts, so bubbles compress out of the pipeline.
    assign advance = !valid_q || next_advance;

    // NOTE: payload registers are reset too, because out_data must read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= in_valid;
            data_q  <= shifted;
            cnt_q   <= in_cnt >> 1;
            mode_q  <= in_mode;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_cnt   = cnt_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined WIDTH-bit shifter/rotator: one registered stage per shift-amount bit,
// LSB first, with a valid/ready handshake and synchronous flush.
`timescale 1ns/1ps
module pipe_shifter
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Index k is the input of stage k; index CNT_W is the last stage's register.
    logic [CNT_W:0]            valid_s;
    logic [CNT_W:0]            adv_s;
    logic [CNT_W:0][WIDTH-1:0] data_s;
    logic [CNT_W:0][CNT_W-1:0] cnt_s;
    logic [CNT_W:0][1:0]       mode_s;
    logic                      unused_tail;

    assign valid_s[0]    = in_valid;
    assign data_s[0]     = in_data;
    assign cnt_s[0]      = in_cnt;
    assign mode_s[0]     = in_mode;
    assign adv_s[CNT_W]  = out_ready;

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W),
            .AMT   (1 << k)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .in_valid     (valid_s[k]),
            .in_data      (data_s[k]),
            .in_cnt       (cnt_s[k]),
            .in_mode      (mode_s[k]),
            .next_advance (adv_s[k+1]),
            .advance      (adv_s[k]),
            .out_valid    (valid_s[k+1]),
            .out_data     (data_s[k+1]),
            .out_cnt      (cnt_s[k+1]),
            .out_mode     (mode_s[k+1])
        );
    end

    // Count and mode are fully consumed by the last stage.
    assign unused_tail = ^{cnt_s[CNT_W], mode_s[CNT_W]};

    assign in_ready  = adv_s[0] && !flush;
    assign out_valid = valid_s[CNT_W];
    assign out_data  = data_s[CNT_W];

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: directed scenarios at WIDTH=16 and 32 plus a
// randomized stream scored against a bit-at-a-time reference model.
`timescale 1ns/1ps
module tb_pipe_shifter;
    import pipe_shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [15:0] in_data = '0, out_data;
    logic [3:0]  in_cnt = '0;
    logic [1:0]  in_mode = '0;

    logic        in_valid_w = 1'b0, in_ready_w, out_valid_w, out_ready_w = 1'b0;
    logic [31:0] in_data_w = '0, out_data_w;
    logic [4:0]  in_cnt_w = '0;
    logic [1:0]  in_mode_w = '0;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_shifter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_cnt(in_cnt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipe_shifter #(.WIDTH(32)) dut_w (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
        .in_cnt(in_cnt_w), .in_mode(in_mode_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: apply the operation one bit position at a time, cnt times.
    function automatic logic [31:0] ref_op(input logic [31:0] d, input int c,
                                           input logic [1:0] m, input int w);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r = d & mask;
        for (int i = 0; i < c; i++) begin
            case (m)
                2'b00:   r = ((r << 1) | (r >> (w - 1))) & mask;
                2'b01:   r = (r << 1) & mask;
                2'b10:   r = (r >> 1) | ((r & 32'd1) << (w - 1));
                default: r = r >> 1;
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for its result; lat counts edges from acceptance.
    task automatic op16(input logic [15:0] d, input logic [3:0] c, input logic [1:0] m,
                        output logic [15:0] res, output int lat);
        int guard;
        in_data = d; in_cnt = c; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin step(); guard++; end
        step();
        in_valid = 1'b0; in_data = 16'($urandom); in_cnt = 4'($urandom); in_mode = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin step(); lat++; end
        res = out_data;
        step();
    endtask

    task automatic op32(input logic [31:0] d, input logic [4:0] c, input logic [1:0] m,
                        output logic [31:0] res, output int lat);
        int guard;
        in_data_w = d; in_cnt_w = c; in_mode_w = m; in_valid_w = 1'b1; out_ready_w = 1'b1;
        #1;
        guard = 0;
        while (!in_ready_w && guard < 20) begin step(); guard++; end
        step();
        in_valid_w = 1'b0; in_data_w = $urandom; in_cnt_w = 5'($urandom);
        lat = 1;
        while (!out_valid_w && lat < 20) begin step(); lat++; end
        res = out_data_w;
        step();
    endtask

    task automatic test_reset();
        step(); step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_tests++; if (out_valid_w !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_w: got %b want 0", out_valid_w); end
        #3 rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (in_ready_w !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_w: got %b want 1", in_ready_w); end
        step();
    endtask

    task automatic test_modes();
        logic [15:0] exp_t [4] = '{16'h00FB, 16'h00F0, 16'hFB00, 16'h0B00};
        logic [15:0] res;
        int lat;
        for (int m = 0; m < 4; m++) begin
            op16(16'hB00F, 4'd4, 2'(m), res, lat);
            n_tests++; if (res !== exp_t[m]) begin n_fail++; $display("FAIL mode%0d_data: got %h want %h", m, res, exp_t[m]); end
            n_tests++; if (lat != 4) begin n_fail++; $display("FAIL mode%0d_latency: got %0d want 4", m, lat); end
        end
    endtask

    task automatic test_count_bounds();
        logic [15:0] exp15 [4] = '{16'hC000, 16'h8000, 16'h0003, 16'h0001};
        logic [15:0] res;
        int lat;
        for (int m = 0; m < 4; m++) begin
            op16(16'h8001, 4'd0, 2'(m), res, lat);
            n_tests++; if (res !== 16'h8001) begin n_fail++; $display("FAIL cnt0_mode%0d: got %h want 8001", m, res); end
            op16(16'h8001, 4'd15, 2'(m), res, lat);
            n_tests++; if (res !== exp15[m]) begin n_fail++; $display("FAIL cnt15_mode%0d: got %h want %h", m, res, exp15[m]); end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        bit take;
        logic [15:0] got[$];
        logic [31:0] e;
        acc = 0;
        out_ready = 1'b0; in_cnt = 4'd1; in_mode = MODE_ROL;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = 16'(acc + 1);
            #1;
            take = in_ready;
            step();
            if (take) acc++;
        end
        n_tests++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h0002) begin
            n_fail++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=0002", out_valid, out_data); end
        step(); step();
        n_tests++; if (out_data !== 16'h0002) begin n_fail++; $display("FAIL bp_stable: got %h want 0002", out_data); end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            in_valid = (acc < 5); in_data = 16'(acc + 1);
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            take = in_valid && in_ready;
            step();
            if (take) acc++;
        end
        in_valid = 1'b0;
        n_tests++; if (got.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            e = ref_op(32'(i + 1), 1, MODE_ROL, 16);
            n_tests++; if (got[i] !== e[15:0]) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], e[15:0]); end
        end
        step(); step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [15:0] res;
        logic [31:0] e;
        int lat;
        out_ready = 1'b1; in_cnt = 4'd1; in_mode = MODE_SLL;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0100 + i);
            step();
        end
        flush = 1'b1; in_data = 16'hDEAD;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d: got out_valid %b data %h want 0", c, out_valid, out_data); end
            step();
        end
        op16(16'h1234, 4'd3, MODE_SLL, res, lat);
        e = ref_op(32'h1234, 3, MODE_SLL, 16);
        n_tests++; if (res !== e[15:0] || lat != 4) begin
            n_fail++; $display("FAIL flush_after: got %h lat %0d want %h lat 4", res, lat, e[15:0]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        logic [31:0] e;
        int lat;
        out_ready = 1'b0; in_cnt = 4'd0; in_mode = MODE_ROL;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'(16'hA5A0 + i);
            step();
        end
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'hA5A0) begin
            n_fail++; $display("FAIL rstmid_full: got v=%b d=%h want v=1 d=a5a0", out_valid, out_data); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_clear: got v=%b d=%h want v=0 d=0000", out_valid, out_data); end
        #3 rst = 1'b0;
        op16(16'h4C3B, 4'd5, MODE_ROR, res, lat);
        e = ref_op(32'h4C3B, 5, MODE_ROR, 16);
        n_tests++; if (res !== e[15:0] || lat != 4) begin
            n_fail++; $display("FAIL rstmid_after: got %h lat %0d want %h lat 4", res, lat, e[15:0]); end
    endtask

    task automatic test_param32();
        logic [31:0] res;
        int lat;
        op32(32'h8000_0001, 5'd31, MODE_SRL, res, lat);
        n_tests++; if (res !== 32'h0000_0001 || lat != 5) begin
            n_fail++; $display("FAIL w32_srl31: got %h lat %0d want 00000001 lat 5", res, lat); end
        op32(32'h8000_0001, 5'd1, MODE_ROL, res, lat);
        n_tests++; if (res !== 32'h0000_0003 || lat != 5) begin
            n_fail++; $display("FAIL w32_rol1: got %h lat %0d want 00000003 lat 5", res, lat); end
    endtask

    task automatic test_random();
        logic [15:0] expq[$];
        logic [31:0] e;
        logic [15:0] hold_d, want;
        bit hold_v;
        int issued, cycles;
        issued = 0; cycles = 0; hold_v = 1'b0; hold_d = '0;
        while ((issued < 10000 || expq.size() > 0) && cycles < 60000) begin
            in_valid  = (issued < 10000) && ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom); in_cnt = 4'($urandom); in_mode = 2'($urandom);
            out_ready = (issued >= 10000) || ($urandom_range(0, 2) != 0);
            #1;
            if (hold_v) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== hold_d) begin
                    n_fail++; $display("FAIL rnd_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, hold_d); end
            end
            if (out_valid && out_ready) begin
                want = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                n_tests++; if (out_data !== want) begin
                    n_fail++; $display("FAIL rnd_data: got %h want %h", out_data, want); end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (in_valid && in_ready) begin
                e = ref_op({16'h0, in_data}, int'(in_cnt), in_mode, 16);
                expq.push_back(e[15:0]);
                issued++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        n_tests++; if (issued != 10000 || expq.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain: issued %0d pending %0d want 10000 and 0", issued, expq.size()); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_count_bounds();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_param32();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
